// File: rtl/cam_ctrl.sv
// Control side of the CAM: serialises requester reads/writes, picks the target
// entry (hit, first free, else LRU victim) and issues one-cycle datapath strobes.
module cam_ctrl #(
  parameter int unsigned camsize_p = 8,
  parameter int unsigned idx_w_p   = $clog2(camsize_p)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_rw_n,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic                              resp_hit,
  output logic                              resp_err,
  output logic [camsize_p-1:0]              write_c_d,
  output logic [camsize_p-1:0]              read_c_d,
  output logic [camsize_p-1:0]              increment_lru_c_d,
  output logic [idx_w_p-1:0]                read_idx_c_d,
  input  logic [camsize_p-1:0]              valids_d_c,
  input  logic [camsize_p-1:0][idx_w_p-1:0] lrus_d_c,
  input  logic [camsize_p-1:0]              hits_d_c
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACT, ST_RESP} state_e;

  localparam logic [idx_w_p-1:0]   AGE_MAX = idx_w_p'(camsize_p - 1);
  localparam logic [camsize_p-1:0] ONE_V   = {{(camsize_p-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [camsize_p-1:0] write_q, write_d, read_q, read_d, inc_q, inc_d;
  logic [idx_w_p-1:0]   read_idx_q, read_idx_d;
  logic                 hit_q, hit_d, err_q, err_d;

  logic                 any_hit, any_free, multi_hit, tgt_valid;
  logic [idx_w_p-1:0]   hit_idx, free_idx, lru_idx, tgt;
  logic [camsize_p-1:0] tgt_oh, lru_inc;

  // Target selection; scanning from the top leaves the lowest matching index.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    any_hit  = 1'b0;
    any_free = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    lru_idx  = '0;
    for (int i = camsize_p - 1; i >= 0; i--) begin
      if (hits_d_c[i]) begin
        any_hit = 1'b1;
        hit_idx = idx_w_p'(i);
      end
      if (!valids_d_c[i]) begin
        any_free = 1'b1;
        free_idx = idx_w_p'(i);
      end
      if (lrus_d_c[i] == AGE_MAX) lru_idx = idx_w_p'(i);
    end
    multi_hit = |(hits_d_c & (hits_d_c - ONE_V));
    tgt       = any_hit ? hit_idx : (any_free ? free_idx : lru_idx);
    tgt_valid = valids_d_c[tgt];
    tgt_oh      = '0;
    tgt_oh[tgt] = 1'b1;
    // Filling a free slot ages every valid entry; otherwise only the younger ones.
    for (int j = 0; j < camsize_p; j++) begin
      lru_inc[j] = valids_d_c[j] &
                   (!tgt_valid | ((idx_w_p'(j) != tgt) && (lrus_d_c[j] < lrus_d_c[tgt])));
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = '0;
    read_d     = '0;
    inc_d      = '0;
    read_idx_d = '0;
    hit_d      = hit_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_ACT;
          hit_d   = any_hit;
          err_d   = err_q | multi_hit;
          if (req_rw_n) begin
            if (any_hit) begin
              read_d     = tgt_oh;
              read_idx_d = tgt;
              inc_d      = lru_inc;
            end
          end else begin
            write_d = tgt_oh;
            inc_d   = lru_inc;
          end
        end
      end
      ST_ACT:  state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      write_q    <= '0;
      read_q     <= '0;
      inc_q      <= '0;
      read_idx_q <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      read_q     <= read_d;
      inc_q      <= inc_d;
      read_idx_q <= read_idx_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
    end
  end

  assign req_ready         = (state_q == ST_IDLE);
  assign resp_valid        = (state_q == ST_RESP);
  assign resp_hit          = resp_valid & hit_q;
  assign resp_err          = err_q;
  assign write_c_d         = write_q;
  assign read_c_d          = read_q;
  assign increment_lru_c_d = inc_q;
  assign read_idx_c_d      = read_idx_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: directed vector table, hand-written reset and
// back-pressure sequences, then random traffic against a behavioural CAM model.
module tb_cam_ctrl;
  localparam int N = 8;
  localparam int W = 3;

  typedef logic [N-1:0][W-1:0] ages_t;
  typedef struct {
    logic         rw_n;
    logic [N-1:0] hits;
    logic [N-1:0] valids;
    ages_t        lrus;
    logic [N-1:0] exp_write;
    logic [N-1:0] exp_read;
    logic [W-1:0] exp_idx;
    logic [N-1:0] exp_inc;
    logic         exp_hit;
    logic         exp_err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, req_valid, req_rw_n, resp_ready;
  logic         req_ready, resp_valid, resp_hit, resp_err;
  logic [N-1:0] write_c_d, read_c_d, increment_lru_c_d, valids, hits;
  logic [W-1:0] read_idx_c_d;
  ages_t        lrus;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural CAM contents: what the datapath would hold.
  bit m_valid[N];
  int m_age[N];
  int m_key[N];
  bit m_err;

  cam_ctrl #(.camsize_p(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw_n(req_rw_n),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_err(resp_err),
    .write_c_d(write_c_d), .read_c_d(read_c_d),
    .increment_lru_c_d(increment_lru_c_d), .read_idx_c_d(read_idx_c_d),
    .valids_d_c(valids), .lrus_d_c(lrus), .hits_d_c(hits)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw_n, input logic [N-1:0] h, input logic [N-1:0] v,
                              input ages_t a, input logic [N-1:0] ew, input logic [N-1:0] er,
                              input logic [W-1:0] ei, input logic [N-1:0] einc,
                              input logic eh, input logic ee);
    vec_t r;
    r.rw_n = rw_n; r.hits = h; r.valids = v; r.lrus = a;
    r.exp_write = ew; r.exp_read = er; r.exp_idx = ei; r.exp_inc = einc;
    r.exp_hit = eh; r.exp_err = ee;
    return r;
  endfunction

  // One full request/strobe/response transaction, checked cycle by cycle.
  task automatic do_op(input vec_t v, input int rdy_delay, input string nm);
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({nm, ":req_ready"}, 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_rw_n   = v.rw_n;
    hits       = v.hits;
    valids     = v.valids;
    lrus       = v.lrus;
    resp_ready = (rdy_delay == 0);
    @(negedge clk);
    req_valid = 1'b0;
    check({nm, ":write"}, 32'(write_c_d), 32'(v.exp_write));
    check({nm, ":read"}, 32'(read_c_d), 32'(v.exp_read));
    check({nm, ":inc"}, 32'(increment_lru_c_d), 32'(v.exp_inc));
    if (v.exp_read != '0) check({nm, ":read_idx"}, 32'(read_idx_c_d), 32'(v.exp_idx));
    check({nm, ":act_resp_valid"}, 32'(resp_valid), 0);
    check({nm, ":err"}, 32'(resp_err), 32'(v.exp_err));
    @(negedge clk);
    check({nm, ":resp_strobes"}, 32'({write_c_d, read_c_d, increment_lru_c_d}), 0);
    check({nm, ":resp_valid"}, 32'(resp_valid), 1);
    check({nm, ":resp_hit"}, 32'(resp_hit), 32'(v.exp_hit));
    for (int d = 0; d < rdy_delay; d++) begin
      @(negedge clk);
      check({nm, ":hold_valid"}, 32'(resp_valid), 1);
      check({nm, ":hold_ready"}, 32'(req_ready), 0);
      check({nm, ":hold_strobes"}, 32'({write_c_d, read_c_d, increment_lru_c_d}), 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check({nm, ":idle_valid"}, 32'(resp_valid), 0);
    check({nm, ":idle_ready"}, 32'(req_ready), 1);
  endtask

  // Derives datapath inputs and expected strobes from the CAM contents, then
  // applies the access to the model (accessed entry becomes youngest).
  task automatic model_step(input bit rw_n, input int key, output vec_t v);
    int t;
    bit hit;
    v = mk(rw_n, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      v.valids[i] = m_valid[i];
      v.lrus[i]   = W'(m_age[i]);
      if (m_valid[i] && m_key[i] == key) v.hits[i] = 1'b1;
    end
    t = -1;
    for (int i = 0; i < N; i++) if (t < 0 && v.hits[i]) t = i;
    hit = (t >= 0);
    for (int i = 0; i < N; i++) if (t < 0 && !m_valid[i]) t = i;
    for (int i = 0; i < N; i++) if (t < 0 && m_age[i] == N - 1) t = i;
    if (t < 0) t = 0;
    m_err     = m_err | ($countones(v.hits) > 1);
    v.exp_hit = hit;
    v.exp_err = m_err;
    if (!rw_n || hit) begin
      for (int j = 0; j < N; j++)
        if (m_valid[j] && j != t && (!m_valid[t] || m_age[j] < m_age[t])) v.exp_inc[j] = 1'b1;
      if (rw_n) begin
        v.exp_read[t] = 1'b1;
        v.exp_idx     = W'(t);
      end else begin
        v.exp_write[t] = 1'b1;
      end
      for (int j = 0; j < N; j++) if (v.exp_inc[j]) m_age[j]++;
      m_age[t]   = 0;
      m_valid[t] = 1'b1;
      m_key[t]   = key;
    end
  endtask

  initial begin
    vec_t  vecs[15];
    vec_t  v;
    ages_t desc, asc, part, fill;
    logic [N-1:0] vmask;
    int    max_age;

    for (int i = 0; i < N; i++) begin
      desc[i] = W'(N - 1 - i);
      asc[i]  = W'(i);
      part[i] = (i < 4) ? W'(3 - i) : '0;
    end
    for (int k = 0; k < N; k++) begin
      fill  = '0;
      for (int i = 0; i < k; i++) fill[i] = W'(k - 1 - i);
      vmask = N'((1 << k) - 1);
      vecs[k] = mk(1'b0, '0, vmask, fill, N'(1 << k), '0, '0, vmask, 1'b0, 1'b0);
    end
    vecs[8]  = mk(1'b0, 8'h00, 8'hFF, desc, 8'h01, 8'h00, 3'd0, 8'hFE, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 8'h10, 8'hFF, desc, 8'h00, 8'h10, 3'd4, 8'hE0, 1'b1, 1'b0);
    vecs[10] = mk(1'b1, 8'h00, 8'hFF, desc, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 8'h08, 8'hFF, desc, 8'h08, 8'h00, 3'd0, 8'hF0, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 8'h00, 8'hFF, asc,  8'h80, 8'h00, 3'd0, 8'h7F, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 8'h00, 8'h0F, part, 8'h10, 8'h00, 3'd0, 8'h0F, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 8'h06, 8'hFF, desc, 8'h02, 8'h00, 3'd0, 8'hFC, 1'b1, 1'b1);

    rst_n = 1'b0; req_valid = 1'b0; req_rw_n = 1'b0; resp_ready = 1'b1;
    hits = '0; valids = '0; lrus = '0;
    repeat (2) @(negedge clk);
    check("reset:strobes", 32'({write_c_d, read_c_d, increment_lru_c_d}), 0);
    check("reset:read_idx", 32'(read_idx_c_d), 0);
    check("reset:resp", 32'({resp_valid, resp_hit, resp_err}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset:req_ready", 32'(req_ready), 1);

    for (int k = 0; k < 15; k++) do_op(vecs[k], 0, $sformatf("vec%0d", k));

    // Sticky error plus five cycles of response back-pressure.
    do_op(mk(1'b1, 8'h00, 8'hFF, desc, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1), 5, "backpressure");

    // Asynchronous reset landing in the strobe cycle.
    req_valid = 1'b1; req_rw_n = 1'b0; hits = '0; valids = 8'h0F; lrus = part;
    @(negedge clk);
    req_valid = 1'b0;
    check("arst:pre_write", 32'(write_c_d), 32'h10);
    check("arst:pre_err", 32'(resp_err), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst:strobes", 32'({write_c_d, read_c_d, increment_lru_c_d}), 0);
    check("arst:err", 32'(resp_err), 0);
    check("arst:req_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst:post_strobes", 32'({write_c_d, read_c_d, increment_lru_c_d}), 0);
      check("arst:post_valid", 32'(resp_valid), 0);
      check("arst:post_ready", 32'(req_ready), 1);
    end

    // Random traffic against the model, starting from an empty CAM.
    m_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_age[i] = 0; m_key[i] = 0;
    end
    for (int n = 0; n < 300; n++) begin
      model_step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 11)), v);
      do_op(v, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end
    max_age = 0;
    for (int i = 0; i < N; i++) if (m_age[i] > max_age) max_age = m_age[i];
    check("model:max_age_bound", 32'(max_age <= N - 1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Control end of the CAM controller/datapath interface: drives write/read strobes, the read index and LRU increments into the CAM datapath.
- Consumes per-entry valid bits, per-entry LRU ages and the one-hot-or-zero hit vector returned by the datapath.
- Serialises requester read/write operations through a 3-state FSM.
- Picks write targets: hit entry, else first invalid entry, else oldest (LRU) entry.

Parameters:
- camsize_p, 8, number of CAM entries; power of two, >=2.
- idx_w_p, $clog2(camsize_p), width of an entry index / LRU age.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  requester has an operation; key/value held stable by requester until resp handshake.
- req_ready  out  1  controller can accept a request.
- req_rw_n  in  1  1 = read (lookup), 0 = write (insert/update).
- resp_valid  out  1  operation complete.
- resp_ready  in  1  requester consumes response.
- resp_hit  out  1  key matched an existing valid entry.
- resp_err  out  1  sticky; multiple hit bits seen.
- write_c_d  out  camsize_p  one-hot-or-zero write strobe.
- read_c_d  out  camsize_p  one-hot-or-zero read strobe.
- increment_lru_c_d  out  camsize_p  per-entry LRU age increment.
- read_idx_c_d  out  idx_w_p  index of entry being read.
- valids_d_c  in  camsize_p  per-entry valid.
- lrus_d_c  in  camsize_p x idx_w_p  per-entry age; 0 = most recent.
- hits_d_c  in  camsize_p  per-entry key match (qualified by valid in datapath).

Behaviour:
- Reset (async, rst_n=0): state IDLE, resp_err=0, all strobes/increments 0, read_idx_c_d=0, resp_valid=0, resp_hit=0. Reset mid-operation aborts it; no strobe is issued after rst_n deassertion until a new request is accepted.
- req_ready = (state==IDLE). Accept when req_valid & req_ready.
- Accept cycle:
  - Register op, hits_d_c, valids_d_c and lrus_d_c into the target/age latch.
  - Compute tgt:
    - Any hit: tgt = lowest set hit bit. If >1 hit bit, set resp_err.
    - Else any invalid entry: tgt = lowest-index invalid entry.
    - Else: tgt = lowest index with lru == camsize_p-1.
  - Go to ACT.
- ACT (exactly one cycle; all strobes registered outputs, high only here):
  - Read hit: read_c_d = onehot(tgt), read_idx_c_d = tgt.
  - Read miss: no strobes, no LRU change.
  - Write (hit, invalid fill, or evict): write_c_d = onehot(tgt).
  - LRU on any strobe: increment_lru_c_d[j]=1 for each valid j != tgt with lru[j] < lru[tgt]. For a fill of an invalid tgt, all valid j are incremented. Datapath clears lru[tgt] to 0 on the strobe.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_hit = hit latched at accept.
  - Hold until resp_ready; then IDLE next cycle, resp_valid=0.
- Latency: accept at cycle N, strobe at N+1, resp_valid at N+2. Back-to-back throughput: one op per 3 cycles when resp_ready is held high.
- Ages never exceed camsize_p-1, because the evicted or accessed entry is always the one compared against.
- resp_err clears only on reset.

Test Plan:
- Reset then 8 writes of distinct keys into an empty CAM (camsize_p=8), hits=0 -> write_c_d = 0x01,0x02,...,0x80 in order; increment_lru_c_d = previous valid mask each time; resp_hit=0.
- Full CAM, ages entry i = 7-i, write miss -> write_c_d=0x01 (age 7); increment_lru_c_d=0xFE.
- Read hit: hits=0x10, ages entry4=3, others 0..7 -> read_c_d=0x10, read_idx_c_d=4, increment exactly entries with age<3, resp_hit=1, resp_valid at accept+2.
- Read miss: hits=0 -> no strobes; increment_lru_c_d=0; resp_valid=1, resp_hit=0.
- Malformed hits=0x06 on a write -> write_c_d=0x02; resp_err=1 and stays 1 through later ops.
- Async reset:
  - rst_n low during ACT -> strobes drop to 0 immediately.
  - resp_valid stays 0 and req_ready=1 after release.
  - resp_ready held low for 5 cycles in RESP -> resp_valid held, req_ready=0, no strobes.
